mem_subword_access_unit: RTL and testbench

Sits between the EX/MEM pipeline register and the 32-bit word-wide data memory. It converts byte addresses to word indices and performs aligned byte, halfword and word loads with sign/zero extension. Sub-word stores are done as a two-cycle read-modify-write, and the unit stalls the pipeline for the extra cycle. Misaligned and out-of-range accesses are flagged and never reach memory.

---
 rtl/mem_subword_access_unit_if.sv | 32 +++
 rtl/mem_subword_access_unit.sv | 129 ++++++++++++
 tb/tb_mem_subword_access_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_subword_access_unit_if.sv
// Bus between the EX/MEM stage, the sub-word access unit and the word-wide data memory.
interface mem_subword_access_unit_if;
  logic [31:0] ALU_Result_MEM;
  logic [31:0] Write_Data_MEM;
  logic        MemRead_MEM;
  logic        MemWrite_MEM;
  logic [1:0]  Mem_Size_MEM;
  logic        Mem_Unsigned_MEM;
  logic [31:0] Dmem_Read_Data;
  logic [31:0] Dmem_Addr;
  logic [31:0] Dmem_Write_Data;
  logic        Dmem_Read;
  logic        Dmem_Write;
  logic [31:0] Load_Data_WB;
  logic        Load_Valid_WB;
  logic        Stall_MEM;
  logic        Access_Exc_MEM;

  modport slave (
    input  ALU_Result_MEM, Write_Data_MEM, MemRead_MEM, MemWrite_MEM,
           Mem_Size_MEM, Mem_Unsigned_MEM, Dmem_Read_Data,
    output Dmem_Addr, Dmem_Write_Data, Dmem_Read, Dmem_Write,
           Load_Data_WB, Load_Valid_WB, Stall_MEM, Access_Exc_MEM
  );

  modport master (
    output ALU_Result_MEM, Write_Data_MEM, MemRead_MEM, MemWrite_MEM,
           Mem_Size_MEM, Mem_Unsigned_MEM, Dmem_Read_Data,
    input  Dmem_Addr, Dmem_Write_Data, Dmem_Read, Dmem_Write,
           Load_Data_WB, Load_Valid_WB, Stall_MEM, Access_Exc_MEM
  );
endinterface

// File: rtl/mem_subword_access_unit.sv
// Big-endian byte/halfword/word access unit in front of a 1024-word data memory.
//   state | meaning
//   IDLE  | accept request: load, word store, error, or start sub-word RMW read
//   MERGE | write merged word from latched RMW context
module mem_subword_access_unit (
  input logic                     Clk,
  input logic                     Reset_n,
  mem_subword_access_unit_if.slave bus
);
  typedef enum logic {IDLE, MERGE} state_t;

  state_t      state, state_nxt;
  logic [31:0] lat_word, lat_mask, lat_data;
  logic [9:0]  lat_addr;

  logic [31:0] addr;
  logic [1:0]  lane, size;
  logic        req, misaligned, out_of_range, err;
  logic [31:0] lane_mask, lane_data, load_ext;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        load_fire, err_fire, rmw_start;

  assign addr = bus.ALU_Result_MEM;
  assign lane = addr[1:0];
  assign size = bus.Mem_Size_MEM;
  assign req  = bus.MemRead_MEM | bus.MemWrite_MEM;

  assign misaligned   = (size == 2'b01 && addr[0]) ||
                        (size == 2'b10 && addr[1:0] != 2'b00) ||
                        (size == 2'b11);
  assign out_of_range = (addr[31:12] != 20'd0);
  assign err          = misaligned | out_of_range;

  always_comb begin
    sel_byte = 8'd0;
    case (lane)
      2'd0: sel_byte = bus.Dmem_Read_Data[31:24];
      2'd1: sel_byte = bus.Dmem_Read_Data[23:16];
      2'd2: sel_byte = bus.Dmem_Read_Data[15:8];
      default: sel_byte = bus.Dmem_Read_Data[7:0];
    endcase
  end

  assign sel_half = addr[1] ? bus.Dmem_Read_Data[15:0] : bus.Dmem_Read_Data[31:16];

  always_comb begin
    load_ext  = bus.Dmem_Read_Data;
    lane_mask = 32'd0;
    lane_data = 32'd0;
    case (size)
      2'b00: begin
        load_ext  = bus.Mem_Unsigned_MEM ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
        lane_mask = 32'hFF00_0000 >> {lane, 3'b000};
        lane_data = {bus.Write_Data_MEM[7:0], 24'd0} >> {lane, 3'b000};
      end
      2'b01: begin
        load_ext  = bus.Mem_Unsigned_MEM ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
        lane_mask = addr[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
        lane_data = addr[1] ? {16'd0, bus.Write_Data_MEM[15:0]}
                            : {bus.Write_Data_MEM[15:0], 16'd0};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt           = state;
    bus.Dmem_Addr       = {22'd0, addr[11:2]};
    bus.Dmem_Write_Data = bus.Write_Data_MEM;
    bus.Dmem_Read       = 1'b0;
    bus.Dmem_Write      = 1'b0;
    bus.Stall_MEM       = 1'b0;
    load_fire           = 1'b0;
    err_fire            = 1'b0;
    rmw_start           = 1'b0;
    case (state)
      IDLE: begin
        if (req && err) begin
          err_fire = 1'b1;
        end else if (bus.MemWrite_MEM) begin
          if (size == 2'b10) begin
            bus.Dmem_Write = 1'b1;
          end else begin
            bus.Dmem_Read = 1'b1;
            bus.Stall_MEM = 1'b1;
            rmw_start     = 1'b1;
            state_nxt     = MERGE;
          end
        end else if (bus.MemRead_MEM) begin
          bus.Dmem_Read = 1'b1;
          load_fire     = 1'b1;
        end
      end
      MERGE: begin
        bus.Dmem_Addr       = {22'd0, lat_addr};
        bus.Dmem_Write_Data = (lat_word & ~lat_mask) | (lat_data & lat_mask);
        // Reset during the merge cycle must not corrupt memory
        bus.Dmem_Write      = Reset_n;
        state_nxt           = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state              <= IDLE;
      bus.Load_Data_WB   <= 32'd0;
      bus.Load_Valid_WB  <= 1'b0;
      bus.Access_Exc_MEM <= 1'b0;
      lat_word           <= 32'd0;
      lat_mask           <= 32'd0;
      lat_data           <= 32'd0;
      lat_addr           <= 10'd0;
    end else begin
      state              <= state_nxt;
      bus.Load_Valid_WB  <= load_fire;
      bus.Access_Exc_MEM <= err_fire;
      if (load_fire) bus.Load_Data_WB <= load_ext;
      if (rmw_start) begin
        lat_word <= bus.Dmem_Read_Data;
        lat_mask <= lane_mask;
        lat_data <= lane_data;
        lat_addr <= addr[11:2];
      end
    end
  end
endmodule

// File: tb/tb_mem_subword_access_unit.sv
// Randomized bench for mem_subword_access_unit against a byte-level reference model.
module tb_mem_subword_access_unit;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_subword_access_unit_if bus ();

  mem_subword_access_unit dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  always #5 Clk = ~Clk;

  // Environment memory driven by the DUT's memory port
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] last_load;

  assign bus.Dmem_Read_Data = (bus.Dmem_Addr[9:0] == 10'd0) ? 32'd0 : mem[bus.Dmem_Addr[9:0]];

  always @(posedge Clk)
    if (bus.Dmem_Write) mem[bus.Dmem_Addr[9:0]] <= bus.Dmem_Write_Data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(input int idx);
    return (idx == 0) ? 32'd0 : ref_mem[idx];
  endfunction

  function automatic bit ref_legal(input logic [31:0] a, input logic [1:0] sz);
    int nbytes;
    if (sz == 2'b11) return 1'b0;
    nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    return (a < 32'd4096) && (a % nbytes == 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input bit uns);
    logic [31:0] w;
    logic [31:0] v;
    int k;
    w = ref_read(int'(a / 4));
    k = int'(a % 4);
    if (sz == 2'b10) return w;
    if (sz == 2'b00) begin
      v = (w >> (8 * (3 - k))) & 32'hFF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end else begin
      v = (w >> (8 * (2 - k))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h1_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] w;
    int k, nb, sh;
    logic [31:0] field;
    if (sz == 2'b10) return wd;
    w  = ref_read(int'(a / 4));
    k  = int'(a % 4);
    nb = (sz == 2'b00) ? 1 : 2;
    sh = 8 * (4 - k - nb);
    field = (nb == 1) ? 32'hFF : 32'hFFFF;
    return (w & ~(field << sh)) | ((wd & field) << sh);
  endfunction

  task automatic set_word(input int idx, input logic [31:0] v);
    mem[idx] = v;
    ref_mem[idx] = v;
  endtask

  task automatic run_op(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                        input bit uns, input logic [31:0] wd);
    bit legal, exp_rd, exp_wr, exp_stall;
    logic [31:0] exp_word;
    int idx;
    legal     = ref_legal(a, sz);
    exp_rd    = legal && (!wr || sz != 2'b10);
    exp_wr    = legal && wr && sz == 2'b10;
    exp_stall = legal && wr && sz != 2'b10;
    idx       = int'(a / 4) % 1024;
    exp_word  = legal && wr ? ref_store(a, sz, wd) : 32'd0;

    @(negedge Clk);
    bus.ALU_Result_MEM   = a;
    bus.Write_Data_MEM   = wd;
    bus.MemRead_MEM      = ~wr;
    bus.MemWrite_MEM     = wr;
    bus.Mem_Size_MEM     = sz;
    bus.Mem_Unsigned_MEM = uns;
    #1;
    chk("dmem_read", {31'd0, bus.Dmem_Read}, {31'd0, exp_rd});
    chk("dmem_write", {31'd0, bus.Dmem_Write}, {31'd0, exp_wr});
    chk("stall", {31'd0, bus.Stall_MEM}, {31'd0, exp_stall});
    if (legal) chk("dmem_addr", bus.Dmem_Addr, a / 4);
    if (exp_wr) chk("word_wdata", bus.Dmem_Write_Data, wd);

    @(posedge Clk); #1;
    chk("access_exc", {31'd0, bus.Access_Exc_MEM}, {31'd0, !legal});
    chk("load_valid", {31'd0, bus.Load_Valid_WB}, {31'd0, legal && !wr});
    if (legal && !wr) last_load = ref_load(a, sz, uns);
    chk("load_data", bus.Load_Data_WB, last_load);

    if (exp_stall) begin
      chk("merge_write", {31'd0, bus.Dmem_Write}, 32'd1);
      chk("merge_stall", {31'd0, bus.Stall_MEM}, 32'd0);
      chk("merge_read", {31'd0, bus.Dmem_Read}, 32'd0);
      chk("merge_addr", bus.Dmem_Addr, a / 4);
      chk("merge_wdata", bus.Dmem_Write_Data, exp_word);
      @(posedge Clk); #1;
      chk("merge_valid", {31'd0, bus.Load_Valid_WB}, 32'd0);
    end

    if (legal && wr) begin
      ref_mem[idx] = exp_word;
      chk("mem_word", mem[idx], exp_word);
    end
    bus.MemRead_MEM  = 1'b0;
    bus.MemWrite_MEM = 1'b0;
    #1;
    chk("idle_stall", {31'd0, bus.Stall_MEM}, 32'd0);
    chk("idle_en", {30'd0, bus.Dmem_Read, bus.Dmem_Write}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    int r;
    logic [1:0] rsz;
    bus.ALU_Result_MEM   = 32'd0;
    bus.Write_Data_MEM   = 32'd0;
    bus.MemRead_MEM      = 1'b0;
    bus.MemWrite_MEM     = 1'b0;
    bus.Mem_Size_MEM     = 2'b00;
    bus.Mem_Unsigned_MEM = 1'b0;
    last_load = 32'd0;
    for (int i = 0; i < 1024; i++) set_word(i, $urandom);

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_valid", {31'd0, bus.Load_Valid_WB}, 32'd0);
    chk("rst_exc", {31'd0, bus.Access_Exc_MEM}, 32'd0);
    chk("rst_data", bus.Load_Data_WB, 32'd0);
    chk("rst_en", {29'd0, bus.Dmem_Read, bus.Dmem_Write, bus.Stall_MEM}, 32'd0);
    Reset_n = 1'b1;

    // Directed scenarios
    set_word(4, 32'h1122_3344);
    run_op(1'b0, 32'h010, 2'b10, 1'b0, 32'd0);
    chk("lw_value", last_load, 32'h1122_3344);
    set_word(4, 32'h1122_F344);
    run_op(1'b0, 32'h012, 2'b00, 1'b0, 32'd0);
    chk("lb_value", last_load, 32'hFFFF_FFF3);
    run_op(1'b0, 32'h012, 2'b00, 1'b1, 32'd0);
    chk("lbu_value", last_load, 32'h0000_00F3);
    run_op(1'b0, 32'h012, 2'b01, 1'b0, 32'd0);
    chk("lh_value", last_load, 32'hFFFF_F344);
    set_word(5, 32'hAABB_CCDD);
    run_op(1'b1, 32'h015, 2'b00, 1'b0, 32'h0000_0077);
    chk("sb_mem", mem[5], 32'hAA77_CCDD);
    set_word(6, 32'hFFFF_FFFF);
    run_op(1'b1, 32'h01A, 2'b01, 1'b0, 32'h0000_1234);
    run_op(1'b0, 32'h018, 2'b10, 1'b0, 32'd0);
    chk("sh_lw_value", last_load, 32'hFFFF_1234);
    run_op(1'b0, 32'h011, 2'b10, 1'b0, 32'd0);
    run_op(1'b1, 32'h013, 2'b01, 1'b0, 32'h0000_BEEF);
    run_op(1'b1, 32'h1000, 2'b00, 1'b0, 32'h0000_00AA);
    run_op(1'b1, 32'h002, 2'b00, 1'b0, 32'h0000_00C3);
    chk("rmw_zero_word", mem[0], 32'h0000_C300);

    // Reset while in MERGE drops the write
    set_word(5, 32'hAABB_CCDD);
    @(negedge Clk);
    bus.ALU_Result_MEM = 32'h014;
    bus.Write_Data_MEM = 32'h55;
    bus.MemWrite_MEM   = 1'b1;
    bus.Mem_Size_MEM   = 2'b00;
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    #1;
    chk("rst_merge_write", {31'd0, bus.Dmem_Write}, 32'd0);
    @(posedge Clk); #1;
    bus.MemWrite_MEM = 1'b0;
    #1;
    chk("rst_merge_mem", mem[5], 32'hAABB_CCDD);
    chk("rst_merge_outs", {28'd0, bus.Dmem_Read, bus.Dmem_Write, bus.Stall_MEM,
                           bus.Load_Valid_WB}, 32'd0);
    chk("rst_merge_exc", {31'd0, bus.Access_Exc_MEM}, 32'd0);
    chk("rst_merge_data", bus.Load_Data_WB, 32'd0);
    last_load = 32'd0;
    Reset_n = 1'b1;

    // Random traffic concentrated on a few words so stores and loads interact
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0)      ra = $urandom;
      else if (r == 1) ra = 32'h1000 + $urandom_range(0, 15);
      else             ra = $urandom_range(0, 63);
      r = $urandom_range(0, 9);
      rsz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      if (r < 9 && $urandom_range(0, 3) != 0) begin
        if (rsz == 2'b01) ra[0] = 1'b0;
        if (rsz == 2'b10) ra[1:0] = 2'b00;
      end
      run_op($urandom_range(0, 1) == 1, ra, rsz, $urandom_range(0, 1) == 1, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
